mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 137 +++++++++++++
 tb/tb_mem_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with req/gnt/rvalid data-memory handshake
// Optional MEM_TIMEOUT_EN adds an outstanding-access timeout that aborts and sets sticky mem_err.
module mem_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ctrl_mem,
  input  logic [4:0]  rd_mem,
  input  logic [63:0] alu_result,
  input  logic [63:0] write_data1,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [63:0] dmem_rdata,
  output logic [1:0]  ctrl_wb,
  output logic [4:0]  rd_wb,
  output logic [63:0] alu_result_wb,
  output logic [63:0] read_data_wb,
  output logic        mem_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state;
  logic [63:0] h_addr;
  logic [63:0] h_wdata;
  logic        h_we;
  logic [1:0]  h_ctrl;
  logic [4:0]  h_rd;

  logic memop;
  logic busy;
  logic completion;
  logic abort;

  assign memop      = ctrl_mem[1] | ctrl_mem[0];
  assign busy       = (state == S_REQ) || (state == S_RESP);
  // Writes finish on grant; reads need the separate response beat.
  assign completion = ((state == S_REQ) && dmem_gnt && h_we) ||
                      ((state == S_RESP) && dmem_rvalid);

`ifdef MEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] tcnt;
  logic          err_q;

  assign abort   = busy && !completion && ((tcnt + CW'(1)) == CW'(TIMEOUT));
  assign mem_err = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      tcnt <= (state == S_IDLE) ? '0 : tcnt + CW'(1);
      if (abort) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign abort          = 1'b0;
  assign mem_err        = 1'b0;
`endif

  assign stall      = ((state == S_IDLE) && memop) || (busy && !completion && !abort);
  assign dmem_req   = (state == S_REQ);
  assign dmem_we    = dmem_req & h_we;
  assign dmem_addr  = dmem_req ? h_addr  : 64'd0;
  assign dmem_wdata = dmem_req ? h_wdata : 64'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      h_addr        <= 64'd0;
      h_wdata       <= 64'd0;
      h_we          <= 1'b0;
      h_ctrl        <= 2'b00;
      h_rd          <= 5'd0;
      ctrl_wb       <= 2'b00;
      rd_wb         <= 5'd0;
      alu_result_wb <= 64'd0;
      read_data_wb  <= 64'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (memop) begin
            h_addr  <= alu_result;
            h_wdata <= write_data1;
            h_we    <= ctrl_mem[0];
            h_ctrl  <= ctrl_mem[3:2];
            h_rd    <= rd_mem;
            ctrl_wb <= 2'b00;
            state   <= S_REQ;
          end else begin
            ctrl_wb       <= ctrl_mem[3:2];
            rd_wb         <= rd_mem;
            alu_result_wb <= alu_result;
            read_data_wb  <= 64'd0;
          end
        end
        S_REQ, S_RESP: begin
          if (completion) begin
            ctrl_wb       <= h_ctrl;
            rd_wb         <= h_rd;
            alu_result_wb <= h_addr;
            read_data_wb  <= h_we ? 64'd0 : dmem_rdata;
            state         <= S_IDLE;
          end else begin
            ctrl_wb <= 2'b00;
            if (abort) begin
              state <= S_IDLE;
            end else if ((state == S_REQ) && dmem_gnt) begin
              state <= S_RESP;
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          ctrl_wb <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage against a transaction-level model
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ctrl_mem;
  logic [4:0]  rd_mem;
  logic [63:0] alu_result;
  logic [63:0] write_data1;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [63:0] dmem_rdata;
  logic [1:0]  ctrl_wb;
  logic [4:0]  rd_wb;
  logic [63:0] alu_result_wb;
  logic [63:0] read_data_wb;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

`ifdef MEM_TIMEOUT_EN
  localparam int MAXD = 1;
`else
  localparam int MAXD = 3;
`endif

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .ctrl_mem(ctrl_mem), .rd_mem(rd_mem),
    .alu_result(alu_result), .write_data1(write_data1), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .ctrl_wb(ctrl_wb), .rd_wb(rd_wb),
    .alu_result_wb(alu_result_wb), .read_data_wb(read_data_wb), .mem_err(mem_err)
  );

  // Model: a memop with grant after g waiting REQ cycles and response after r
  // waiting RESP cycles completes in cycle g+1 (store) or g+r+2 (load).
  task automatic run_instr(input logic [3:0] ctrl, input logic [4:0] rd, input logic [63:0] addr,
                           input logic [63:0] wdata, input int g, input int r,
                           input logic [63:0] rdata, input string name);
    bit mem = ctrl[1] | ctrl[0];
    bit wr  = ctrl[0];
    int c   = !mem ? 0 : (wr ? g + 1 : g + r + 2);
    bit exp_stall;
    bit exp_req;
    logic [63:0] exp_rdata;
    for (int k = 0; k <= c; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) begin
        ctrl_mem = ctrl; rd_mem = rd; alu_result = addr; write_data1 = wdata;
      end else if (k == c) begin
        ctrl_mem = 4'($urandom); rd_mem = 5'($urandom);
        alu_result = {$urandom, $urandom}; write_data1 = {$urandom, $urandom};
      end
      exp_req     = mem && (k >= 1) && (k <= g + 1);
      dmem_gnt    = mem && (k == g + 1);
      dmem_rvalid = (mem && !wr && (k == c)) || (exp_req && ($urandom_range(0, 1) == 1));
      dmem_rdata  = (k == c) ? rdata : {$urandom, $urandom};
      #1;
      exp_stall = (k < c);
      checks++;
      if (stall !== exp_stall) begin
        errors++;
        $display("FAIL %s stall k=%0d got %b exp %b", name, k, stall, exp_stall);
      end
      checks++;
      if (dmem_req !== exp_req) begin
        errors++;
        $display("FAIL %s dmem_req k=%0d got %b exp %b", name, k, dmem_req, exp_req);
      end
      if (exp_req) begin
        checks++;
        if (dmem_we !== wr || dmem_addr !== addr || dmem_wdata !== wdata) begin
          errors++;
          $display("FAIL %s dmem_bus k=%0d got we=%b a=%h d=%h exp we=%b a=%h d=%h",
                   name, k, dmem_we, dmem_addr, dmem_wdata, wr, addr, wdata);
        end
      end else begin
        checks++;
        if (dmem_addr !== 64'd0 || dmem_wdata !== 64'd0) begin
          errors++;
          $display("FAIL %s idle_bus k=%0d got a=%h d=%h exp 0", name, k, dmem_addr, dmem_wdata);
        end
      end
      if (k >= 1) begin
        checks++;
        if (ctrl_wb !== 2'b00) begin
          errors++;
          $display("FAIL %s bubble k=%0d got ctrl_wb=%b exp 00", name, k, ctrl_wb);
        end
      end
    end
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    #1;
    exp_rdata = (mem && !wr) ? rdata : 64'd0;
    checks++;
    if (ctrl_wb !== ctrl[3:2] || rd_wb !== rd || alu_result_wb !== addr || read_data_wb !== exp_rdata) begin
      errors++;
      $display("FAIL %s wb got c=%b rd=%0d a=%h d=%h exp c=%b rd=%0d a=%h d=%h", name,
               ctrl_wb, rd_wb, alu_result_wb, read_data_wb, ctrl[3:2], rd, addr, exp_rdata);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ctrl_mem = 4'd0; rd_mem = 5'd0; alu_result = 64'd0; write_data1 = 64'd0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 64'd0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({stall, dmem_req, dmem_we, ctrl_wb, rd_wb, mem_err} !== 11'd0 ||
        dmem_addr !== 64'd0 || dmem_wdata !== 64'd0 || alu_result_wb !== 64'd0 || read_data_wb !== 64'd0) begin
      errors++;
      $display("FAIL reset outputs got st=%b rq=%b c=%b rd=%0d err=%b exp all 0",
               stall, dmem_req, ctrl_wb, rd_wb, mem_err);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    run_instr(4'b1000, 5'd5, 64'h2A, 64'h0, 0, 0, 64'h0, "alu_op");
    run_instr(4'b0001, 5'd0, 64'h100, 64'hDEAD, 0, 0, 64'h0, "store_imm");
    run_instr(4'b1110, 5'd7, 64'h80, 64'h0, (MAXD > 1) ? 2 : 1, (MAXD > 1) ? 2 : 1, 64'h1234, "load_delay");
    run_instr(4'b0011, 5'd4, 64'h200, 64'hBEEF, 1, 0, 64'h0, "both_bits");
  endtask

  task automatic test_back_to_back();
    run_instr(4'b1000, 5'd1, 64'h11, 64'h0, 0, 0, 64'h0, "b2b_alu0");
    run_instr(4'b1110, 5'd2, 64'h40, 64'h0, 0, 0, 64'h5555, "b2b_load_min");
    run_instr(4'b1000, 5'd3, 64'h33, 64'h0, 0, 0, 64'h0, "b2b_alu1");
    run_instr(4'b0001, 5'd4, 64'h48, 64'h77, 0, 0, 64'h0, "b2b_store");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_instr(4'($urandom), 5'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                int'($urandom_range(0, MAXD)), int'($urandom_range(0, MAXD)),
                {$urandom, $urandom}, "random");
    end
  endtask

  task automatic test_reset_mid();
    ctrl_mem = 4'b1110; rd_mem = 5'd6; alu_result = 64'h90; write_data1 = 64'h0;
    @(negedge clk);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; ctrl_mem = 4'b1000; rd_mem = 5'd9; alu_result = 64'hABC;
    dmem_rvalid = 1'b1; dmem_rdata = 64'hFFFF;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || stall !== 1'b0 || ctrl_wb !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid after got rq=%b st=%b c=%b exp 0 0 00", dmem_req, stall, ctrl_wb);
    end
    @(negedge clk);
    dmem_rvalid = 1'b0;
    #1;
    checks++;
    if (ctrl_wb !== 2'b10 || rd_wb !== 5'd9 || alu_result_wb !== 64'hABC || read_data_wb !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid rvalid_ignored got c=%b rd=%0d a=%h d=%h exp 10 9 abc 0",
               ctrl_wb, rd_wb, alu_result_wb, read_data_wb);
    end
  endtask

  task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
    ctrl_mem = 4'b1110; rd_mem = 5'd3; alu_result = 64'h60; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 4) ctrl_mem = 4'd0;
      #1;
      checks++;
      if (stall !== (k < 4)) begin
        errors++;
        $display("FAIL timeout stall k=%0d got %b exp %b", k, stall, (k < 4));
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (mem_err !== 1'b1 || dmem_req !== 1'b0 || ctrl_wb !== 2'b00) begin
      errors++;
      $display("FAIL timeout abort got err=%b rq=%b c=%b exp 1 0 00", mem_err, dmem_req, ctrl_wb);
    end
    run_instr(4'b1000, 5'd8, 64'h99, 64'h0, 0, 0, 64'h0, "after_timeout");
    checks++;
    if (mem_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout sticky got mem_err=%b exp 1", mem_err);
    end
`else
    checks++;
    if (mem_err !== 1'b0) begin
      errors++;
      $display("FAIL mem_err_tied got %b exp 0", mem_err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
